// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap or saturate mode,
// synchronous load/clear, terminal-count and overflow flags.
module updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             limit;

    assign tc    = up ? (count_q == MAX_C) : (count_q == '0);
    assign limit = en && tc;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = RST_C;
            ovf_d   = 1'b0;
        end else if (load) begin
            // out-of-range loads clamp so count never leaves 0..MAX_VAL
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            ovf_d   = 1'b0;
        end else if (limit) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
            if (WRAP != 0) begin
                count_d = up ? '0 : MAX_C;
            end
        end else if (en) begin
            count_d = up ? (count_q + ONE_C) : (count_q - ONE_C);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_C;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule
